// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the MEM-stage access unit: access opcodes,
// exception bit positions, bus size codes, FSM states and the bus request struct.
package mem_access_unit_pkg;

  localparam logic [7:0] MEM_LB  = 8'h20;
  localparam logic [7:0] MEM_LH  = 8'h21;
  localparam logic [7:0] MEM_LW  = 8'h23;
  localparam logic [7:0] MEM_LBU = 8'h24;
  localparam logic [7:0] MEM_LHU = 8'h25;
  localparam logic [7:0] MEM_SB  = 8'h28;
  localparam logic [7:0] MEM_SH  = 8'h29;
  localparam logic [7:0] MEM_SW  = 8'h2b;

  localparam int EXC_ADEL_BIT = 4;
  localparam int EXC_ADES_BIT = 5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic        ZeroBit  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // Bus size code implied by an access opcode; anything unknown is a word.
  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = SIZE_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: op_size = SIZE_HALF;
      default:                 op_size = SIZE_WORD;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: align_mask = 2'b00;
      SIZE_HALF: align_mask = 2'b01;
      default:   align_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus: request channel (req/wr/size/addr/wdata) with addr_ok
// acceptance, and a response channel (data_ok/rdata).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Lane formatting: replicates store data across the byte lanes the bus
// expects, and extracts/extends the addressed part of returned load data.
module mem_lane_fmt
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  mem_control,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] db,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store replication by access size.
  always_comb begin
    wdata = db;
    case (op_size(mem_control))
      SIZE_BYTE: wdata = {4{db[7:0]}};
      SIZE_HALF: wdata = {2{db[15:0]}};
      default:   wdata = db;
    endcase
  end

  // Load lane select plus sign/zero extension.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (mem_control)
      MEM_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: rdata_ext = {24'h0, byte_sel};
      MEM_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: rdata_ext = {16'h0, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store requests into SRAM-like bus
// transactions, holds the pipeline until each access completes, and flags
// address errors. Optional feature macro: MEM_ADDR_CHECK_EN (alignment check
// with ADEL/ADES; when undefined the address is force-aligned instead).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         stall,
  input  logic               i_write_mem,
  input  logic               i_mem_to_regfile,
  input  logic               i_write_regfile,
  input  logic [31:0]        i_da,
  input  logic [31:0]        i_db,
  input  logic [4:0]         i_rn,
  input  logic [7:0]         i_mem_control,
  input  logic [31:0]        i_except,
  input  logic               i_flush,
  mem_access_unit_if.master  bus,
  output logic [31:0]        o_result,
  output logic               o_write_regfile,
  output logic [4:0]         o_rn,
  output logic [31:0]        o_except,
  output logic [31:0]        o_badvaddr,
  output logic               o_stallreq
);

  state_e            state_q, state_d;
  logic [31:0]       load_q, load_d;
  logic              is_mem, addr_err, access, req_c;
  logic [1:0]        size;
  logic [31:0]       addr_al, exc_bits, badv, wdata_fmt, rdata_ext;
  logic [DATA_W-1:0] rdata_w;
  bus_req_t          breq;
  logic              unused_stall;

  // Only the EX/MEM hold bit matters here.
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  assign size   = op_size(i_mem_control);
  assign is_mem = i_write_mem | i_mem_to_regfile;

`ifdef MEM_ADDR_CHECK_EN
  // Misaligned accesses raise ADEL/ADES and never reach the bus.
  always_comb begin
    addr_err               = is_mem & (|(i_da[1:0] & align_mask(size)));
    addr_al                = i_da;
    exc_bits               = ZeroWord;
    exc_bits[EXC_ADEL_BIT] = addr_err & ~i_write_mem;
    exc_bits[EXC_ADES_BIT] = addr_err & i_write_mem;
    badv                   = addr_err ? i_da : ZeroWord;
  end
`else
  // No checking: drop the low address bits the access size cannot use.
  always_comb begin
    addr_err = ZeroBit;
    addr_al  = {i_da[31:2], i_da[1:0] & ~align_mask(size)};
    exc_bits = ZeroWord;
    badv     = ZeroWord;
  end
`endif

  assign access  = is_mem & ~addr_err & (i_except == ZeroWord) & ~i_flush;
  assign rdata_w = bus.data_rdata;

  mem_lane_fmt u_fmt (
    .mem_control (i_mem_control),
    .addr_lo     (addr_al[1:0]),
    .db          (i_db),
    .rdata       (rdata_w[31:0]),
    .wdata       (wdata_fmt),
    .rdata_ext   (rdata_ext)
  );

  // State and captured load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      load_q  <= ZeroWord;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  // Next state, bus request and load capture. A same-cycle addr_ok+data_ok
  // skips DATA entirely, giving the 2-cycle minimum latency.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    req_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ADDR: begin
        if (!access) begin
          state_d = ST_IDLE;
        end else begin
          req_c = 1'b1;
          if (bus.data_addr_ok && bus.data_data_ok) begin
            state_d = ST_DONE;
            if (i_mem_to_regfile) load_d = rdata_ext;
          end else if (bus.data_addr_ok) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_DATA: begin
        if (bus.data_data_ok) begin
          state_d = i_flush ? ST_IDLE : ST_DONE;
          if (!i_flush && i_mem_to_regfile) load_d = rdata_ext;
        end else if (i_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  if (!stall[3]) state_d = ST_IDLE;
      ST_DRAIN: if (bus.data_data_ok) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus fields are only driven while an access is live.
  always_comb begin
    breq = '0;
    if (access) begin
      breq.wr    = i_write_mem;
      breq.size  = size;
      breq.addr  = addr_al;
      breq.wdata = wdata_fmt;
    end
  end

  // Outputs are forced to zero while reset is held.
  assign bus.data_req   = reset & req_c;
  assign bus.data_wr    = reset & breq.wr;
  assign bus.data_size  = reset ? breq.size : 2'd0;
  assign bus.data_addr  = reset ? ADDR_W'(breq.addr) : '0;
  assign bus.data_wdata = reset ? DATA_W'(breq.wdata) : '0;

  assign o_result        = !reset ? ZeroWord :
                           (state_q == ST_DONE && i_mem_to_regfile) ? load_q : i_da;
  assign o_write_regfile = reset & i_write_regfile & ~addr_err & (state_q != ST_DRAIN);
  assign o_rn            = reset ? i_rn : 5'd0;
  assign o_except        = reset ? (i_except | exc_bits) : ZeroWord;
  assign o_badvaddr      = reset ? badv : ZeroWord;
  assign o_stallreq      = reset & ((access & (state_q != ST_DONE)) | (state_q == ST_DRAIN));

endmodule
